extmem_arbiter: RTL and testbench

- Shares the single external-memory port between N_REQ requesters. Requesters include the controller's MEM_LOAD/MEM_SAVE engine, the SPI debug path and the weight prefetcher.
- Arbitration is round-robin with bounded bursts. The owner's request fields are muxed onto the memory port.
- Read data is returned to the issuing requester with a tagged valid after a fixed read latency.
- Sits between the requesters and the external memory interface at top level.

---
 rtl/extmem_arbiter.sv | 131 +++++++++++++
 tb/tb_extmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/extmem_arbiter.sv
// rtl/extmem_arbiter.sv - round-robin arbiter sharing one external-memory port
// between N_REQ requesters, with bounded bursts and tagged read return.
module extmem_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64,
  parameter int RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic                      busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   owner_inc;
  logic [CNT_W-1:0]  beat_cnt;
  logic              owner_req;
  logic              owner_we;
  logic              beat;
  logic              last_beat;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;
  int                idx;

  logic [RD_LAT-1:0] rp_vld;
  logic [ID_W-1:0]   rp_id [RD_LAT];

  // Lowest offset from rr_ptr wins, so iterate offsets from high to low.
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) pick = idx[ID_W-1:0];
    end
  end

  assign owner_req   = req[owner];
  assign owner_we    = req_we[owner];
  assign owner_addr  = req_addr[owner*ADDR_W +: ADDR_W];
  assign owner_wdata = req_wdata[owner*DATA_W +: DATA_W];
  assign beat        = (state == OWN) && owner_req;
  assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign owner_inc   = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    gnt = '0;
    if (state == OWN) gnt[owner] = owner_req;
  end

  assign mem_we      = beat & owner_we;
  assign mem_re      = beat & ~owner_we;
  assign mem_wr_addr = mem_we ? owner_addr  : '0;
  assign mem_wr_data = mem_we ? owner_wdata : '0;
  assign mem_rd_addr = mem_re ? owner_addr  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (!owner_req || last_beat) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read tags travel with fixed latency, so returns ignore later grant changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) rp_id[i] <= '0;
    end else begin
      rp_vld[0] <= mem_re;
      rp_id[0]  <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        rp_vld[i] <= rp_vld[i-1];
        rp_id[i]  <= rp_id[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (rp_vld[RD_LAT-1]) rvalid[rp_id[RD_LAT-1]] = 1'b1;
  end

  assign rdata = mem_rd_data;
  assign busy  = (state == OWN) || (|rp_vld);

endmodule

// File: tb/tb_extmem_arbiter.sv
// tb/tb_extmem_arbiter.sv - self-checking bench for extmem_arbiter
module tb_extmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int RL = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we, gnt, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata, mem_wr_data, mem_rd_data;
  logic            mem_we, mem_re, busy;
  logic [AW-1:0]   mem_wr_addr, mem_rd_addr;

  typedef struct {int id; logic [15:0] data; int due;} rd_t;
  rd_t         sb[$];
  logic [15:0] mp [RL];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  extmem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wr_addr(mem_wr_addr),
    .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rd_data = mp[RL-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Memory model returns addr[15:0] RL cycles after mem_re; scoreboard checks returns.
  always @(negedge clk) begin
    rd_t e;
    int  id;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < RL; i++) mp[i] = 16'hDEAD;
    end else begin
      chk("we_re_excl", {63'd0, mem_we & mem_re}, 64'd0);
      if (rvalid != '0 || (sb.size() > 0 && sb[0].due == cyc)) begin
        if (sb.size() == 0) begin
          chk("rv_extra", rvalid, 0);
        end else begin
          e = sb.pop_front();
          chk("rv_cyc", cyc, e.due);
          chk("rv_id", rvalid, 3'b001 << e.id);
          chk("rv_data", rdata, e.data);
        end
      end
      for (int i = RL - 1; i > 0; i--) mp[i] = mp[i-1];
      mp[0] = mem_re ? mem_rd_addr[15:0] : 16'hDEAD;
      if (mem_re) begin
        id = 0;
        for (int i = 0; i < N; i++)
          if (req[i] && !req_we[i] && req_addr[i*AW +: AW] == mem_rd_addr) id = i;
        sb.push_back('{id: id, data: mem_rd_addr[15:0], due: cyc + RL});
      end
    end
  end

  initial begin
    logic [N-1:0] exp_gnt;
    logic         exp_we;

    rst = 1'b1;
    req = 3'b111;
    req_we = 3'b111;
    req_addr = '0;
    req_wdata = '0;
    set_addr(0, 32'h10);
    set_addr(1, 32'h20);
    set_addr(2, 32'h30);
    req_wdata[0*DW +: DW] = 16'hA000;
    req_wdata[2*DW +: DW] = 16'hA002;
    for (int i = 0; i < RL; i++) mp[i] = 16'hDEAD;

    // reset with all requests high
    repeat (3) begin
      next();
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rv", rvalid, 0);
      chk("rst_waddr", mem_wr_addr, 0);
    end
    next(); rst = 1'b0; #1;
    chk("post_rst_idle", gnt, 3'b000);
    next(); #1;
    chk("post_rst_gnt", gnt, 3'b001);
    chk("post_rst_we", mem_we, 1);
    chk("post_rst_wa", mem_wr_addr, 32'h10);
    chk("post_rst_busy", busy, 1);
    next(); req = 3'b000; #1;
    chk("drop_gnt", gnt, 0);
    chk("drop_we", mem_we, 0);
    chk("drop_busy", busy, 1);
    next(); #1;
    chk("idle_busy", busy, 0);

    // single reader, requester 1, four beats
    next(); req_we = 3'b000; set_addr(1, 32'h100); req = 3'b010; #1;
    chk("rd_arb", gnt, 0);
    for (int k = 0; k < 4; k++) begin
      next();
      if (k > 0) set_addr(1, 32'h100 + k);
      #1;
      chk("rd_gnt", gnt, 3'b010);
      chk("rd_re", mem_re, 1);
      chk("rd_addr", mem_rd_addr, 32'h100 + k);
    end
    next(); req = 3'b000; #1;
    chk("rd_end", mem_re, 0);
    repeat (5) next();
    #1;
    chk("rd_drain_busy", busy, 0);
    chk("rd_sb_empty", sb.size(), 0);

    // burst cap: requesters 0 and 2 writing continuously, rotation starts at 2
    next(); req_we = 3'b111; set_addr(0, 32'h2000); set_addr(2, 32'h2200); req = 3'b101;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next();
      #1;
      exp_we  = (c % 5) != 0;
      exp_gnt = !exp_we ? 3'b000 : (((c / 5) % 2 == 0) ? 3'b100 : 3'b001);
      chk("bc_we", mem_we, exp_we);
      chk("bc_gnt", gnt, exp_gnt);
      if (exp_we) chk("bc_wdata", mem_wr_data, (exp_gnt == 3'b100) ? 16'hA002 : 16'hA000);
      else        chk("bc_idle_addr", mem_wr_addr, 0);
    end
    next(); req = 3'b000; #1;
    chk("bc_end", gnt, 0);

    // early release by requester 1 while requester 0 waits
    next(); set_addr(1, 32'h2100); req = 3'b010; #1;
    chk("er_arb", gnt, 0);
    next(); req = 3'b011; #1;
    chk("er_gnt1", gnt, 3'b010);
    chk("er_we1", mem_we, 1);
    next(); #1;
    chk("er_gnt2", gnt, 3'b010);
    next(); req = 3'b001; #1;
    chk("er_drop_gnt", gnt, 0);
    chk("er_drop_we", mem_we, 0);
    next(); #1;
    chk("er_arb2", gnt, 0);
    next(); #1;
    chk("er_gnt0", gnt, 3'b001);
    chk("er_addr0", mem_wr_addr, 32'h2000);
    next(); req = 3'b000; #1;
    chk("er_end", gnt, 0);

    // reads across a handoff: owner 0 reads, requester 1 writes next
    next(); req_we = 3'b110; set_addr(0, 32'h3000); req = 3'b001; #1;
    chk("ho_arb", gnt, 0);
    for (int k = 0; k < 4; k++) begin
      next();
      if (k > 0) set_addr(0, 32'h3000 + k);
      if (k == 0) req = 3'b011;
      #1;
      chk("ho_gnt0", gnt, 3'b001);
      chk("ho_re", mem_re, 1);
    end
    next(); req = 3'b010; #1;
    chk("ho_idle", gnt, 0);
    next(); #1;
    chk("ho_gnt1", gnt, 3'b010);
    chk("ho_we1", mem_we, 1);
    next(); #1;
    chk("ho_gnt1b", gnt, 3'b010);
    chk("ho_rv0", rvalid, 3'b001);
    chk("ho_rdata", rdata, 16'h3003);
    next(); req = 3'b000; #1;
    chk("ho_rv_after", rvalid, 0);
    repeat (3) next();

    // reset one cycle after a read issue discards the return
    next(); req_we = 3'b000; set_addr(2, 32'h4000); req = 3'b100; #1;
    chk("rr_arb", gnt, 0);
    next(); #1;
    chk("rr_re", mem_re, 1);
    next(); req = 3'b000; rst = 1'b1; #1;
    chk("rr_busy_rst", busy, 0);
    chk("rr_rv_rst", rvalid, 0);
    next(); rst = 1'b0; #1;
    chk("rr_busy_post", busy, 0);
    for (int k = 0; k < 5; k++) begin
      next(); #1;
      chk("rr_no_rv", rvalid, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
